conv_bias_add_stream: RTL and testbench
=======================================

// Module: conv_bias_add_stream
// PURPOSE
//  Consumer side of the per-layer bias ROMs. Drives ROM row = channel index, col = 0;
//  reads the Q1.7 bias combinationally and adds it to the conv accumulator stream.
//  Requantizes the sum to Q1.7 with saturation, optionally applies ReLU.
//  Sits between the conv MAC array and the next layer's feature buffer; valid/ready on both sides.
// PARAMETERS
//  NUM_CH    64   output channels = bias ROM depth; channel index counts fastest
//  NUM_PIX   256  output pixels per layer pass
//  ACC_W     24   signed accumulator width, Q(ACC_W-14).14 (sum of Q1.7*Q1.7 products)
//  ACC_FRAC  14   accumulator fraction bits; bias is aligned by <<(ACC_FRAC-7)
//  RELU_EN   1    1: clamp negative results to 0 after saturation
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  start      in   1      one-cycle pulse, begins a layer pass (honoured in IDLE only)
//  busy       out  1      high in RUN and DRAIN
//  done       out  1      one-cycle pulse after the last result is accepted downstream
//  in_valid   in   1      accumulator word valid
//  in_ready   out  1      stage can accept in_data this cycle
//  in_data    in   ACC_W  signed accumulator for (pix_cnt, ch_cnt)
//  bias_row   out  16     ROM row address = ch_cnt, zero-extended
//  bias_col   out  16     ROM column address, constant 0
//  bias_data  in   8      signed Q1.7 bias, combinational from bias_row/bias_col
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  8      signed Q1.7 result
//  out_ch     out  16     channel index of out_data
// BEHAVIOUR
//  Reset: state=IDLE; ch_cnt, pix_cnt=0; out_valid=0; out_data=0; out_ch=0; done=0; busy=0.
//    in_ready=0. Reset mid-pass discards any held result; no done pulse.
//  FSM:
//    IDLE -> RUN on start. start in RUN/DRAIN is ignored.
//    RUN -> DRAIN when the last input is accepted (ch_cnt=NUM_CH-1, pix_cnt=NUM_PIX-1).
//    DRAIN -> IDLE when out_valid && out_ready; done=1 on that cycle's following edge, one cycle only.
//  Handshake:
//    in_ready = (state==RUN) && (!out_valid || out_ready).
//    Input accept = in_valid && in_ready. out_valid holds, and out_data/out_ch stay stable, until out_ready.
//    Latency: exactly 1 cycle from accept to out_valid. Back-to-back accepts allowed (full throughput).
//  Counters advance only on input accept.
//    ch_cnt wraps NUM_CH-1 -> 0 and then increments pix_cnt.
//    On the last accept both counters clear to 0.
//  Arithmetic, computed on the accept cycle with bias_data for the current ch_cnt:
//    sum = in_data + (sign_ext(bias_data) <<< (ACC_FRAC-7)), width ACC_W+1, no overflow.
//    q = sum >>> (ACC_FRAC-7) (floor). Saturate q to [-128, 127].
//    If RELU_EN and q<0, then q=0. out_data=q[7:0]; out_ch=ch_cnt.
//  Simultaneous out handshake and new accept on the same cycle: the register reloads. No bubble, no loss.
// TESTING
//  Bench models the ROM with bias[ch] = ch-32 (Q1.7 codes), NUM_CH=4, NUM_PIX=2.
//  1. start, in_data=0 for all 8 words, out_ready=1, RELU_EN=0 -> out_data -32,-31,-30,-29 twice; done 1 cycle after 8th.
//  2. ch0 in_data=160<<7, bias -32 -> q=128 -> out_data=127 (saturate); in_data=-200<<7, bias -32 -> -128.
//  3. RELU_EN=1, ch1 in_data=-5<<7, bias -31 -> out_data=0; in_data=40<<7 -> 9.
//  4. out_ready held 0 for 5 cycles -> out_valid and out_data stable, in_ready=0; release -> stream resumes, no drop.
//  5. rst asserted after 3 accepts -> next cycle out_valid=0, busy=0; restart -> first out_ch=0.
//  6. start pulsed during RUN -> ignored; counters unchanged; exactly 8 outputs, one done.

Source files
------------

// File: rtl/conv_bias_add_stream.sv
// conv_bias_add_stream: adds the per-channel Q1.7 bias to the conv accumulator
// stream, requantizes to Q1.7 with saturation and optional ReLU.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        one-cycle pulse that begins a layer pass (IDLE only)
//   busy         high while a pass is running or draining
//   done         one-cycle pulse after the last result leaves the stage
//   in_valid     accumulator word valid
//   in_ready     stage accepts in_data this cycle
//   in_data      signed Q(ACC_W-ACC_FRAC).ACC_FRAC accumulator
//   bias_row     bias ROM row address (current channel)
//   bias_col     bias ROM column address (always 0)
//   bias_data    signed Q1.7 bias, combinational from bias_row/bias_col
//   out_valid    result valid
//   out_ready    downstream accepts result
//   out_data     signed Q1.7 result
//   out_ch       channel index of out_data

module conv_bias_add_stream #(
    parameter int NUM_CH   = 64,
    parameter int NUM_PIX  = 256,
    parameter int ACC_W    = 24,
    parameter int ACC_FRAC = 14,
    parameter bit RELU_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    output logic [15:0]      bias_row,
    output logic [15:0]      bias_col,
    input  logic [7:0]       bias_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [15:0]      out_ch
);

    // Distance between the accumulator binary point and the Q1.7 point.
    localparam int SH = ACC_FRAC - 7;

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);

    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W + 1)'(127);
    localparam logic signed [ACC_W:0] Q_MIN = (ACC_W + 1)'(-128);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic             done_nx;
    logic [CH_W-1:0]  ch_cnt;
    logic [PIX_W-1:0] pix_cnt;

    logic accept;
    logic out_fire;
    logic last_word;

    logic signed [ACC_W:0] acc_se;
    logic signed [ACC_W:0] bias_se;
    logic signed [ACC_W:0] bias_al;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] q_full;
    logic [7:0]            q8;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------

    // The output register can take a new word when empty or when its
    // current word leaves on this same edge.
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_word = (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);

    assign busy = (state == RUN) || (state == DRAIN);

    // ------------------------------------------------------------------
    // Bias ROM address
    // ------------------------------------------------------------------

    assign bias_row = {{(16 - CH_W){1'b0}}, ch_cnt};
    assign bias_col = 16'h0000;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (accept && last_word) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Channel / pixel counters (channel counts fastest)
    // ------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (accept) begin
            if (ch_cnt == CH_LAST) begin
                ch_cnt <= '0;
                if (pix_cnt == PIX_LAST) begin
                    pix_cnt <= '0;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end else begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bias add and requantization
    // ------------------------------------------------------------------

    // One extra bit of headroom so the sum can never wrap.
    assign acc_se  = {in_data[ACC_W-1], in_data};
    assign bias_se = {{(ACC_W - 7){bias_data[7]}}, bias_data};
    assign bias_al = bias_se <<< SH;
    assign sum     = acc_se + bias_al;

    // Arithmetic shift floors toward minus infinity.
    assign q_full = sum >>> SH;

    always_comb begin
        q8 = q_full[7:0];
        if (q_full > Q_MAX) begin
            q8 = 8'h7F;
        end else if (q_full < Q_MIN) begin
            q8 = 8'h80;
        end
        if (RELU_EN && q8[7]) begin
            q8 = 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------

    // Accept takes priority: a simultaneous drain and accept reloads
    // the register without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_ch    <= 16'h0000;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= q8;
            out_ch    <= {{(16 - CH_W){1'b0}}, ch_cnt};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_bias_add_stream.sv
// tb_conv_bias_add_stream: directed bench for conv_bias_add_stream with a
// bias ROM of bias[ch] = ch-32, NUM_CH=4, NUM_PIX=2; ReLU off and on in lockstep.

module tb_conv_bias_add_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [23:0] in_data;
    logic        out_ready;

    logic        busy_a, done_a, in_ready_a, out_valid_a;
    logic [15:0] bias_row_a, bias_col_a, out_ch_a;
    logic [7:0]  bias_data_a, out_data_a;

    logic        busy_b, done_b, in_ready_b, out_valid_b;
    logic [15:0] bias_row_b, bias_col_b, out_ch_b;
    logic [7:0]  bias_data_b, out_data_b;

    int vectors = 0;
    int errors  = 0;
    int n_out   = 0;
    int n_done  = 0;
    int base_out;
    int base_done;

    always #5 clk = ~clk;

    // Bias ROM model: Q1.7 code ch-32.
    assign bias_data_a = bias_row_a[7:0] - 8'd32;
    assign bias_data_b = bias_row_b[7:0] - 8'd32;

    conv_bias_add_stream #(
        .NUM_CH(4), .NUM_PIX(2), .ACC_W(24), .ACC_FRAC(14), .RELU_EN(1'b0)
    ) u_lin (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .bias_row(bias_row_a), .bias_col(bias_col_a), .bias_data(bias_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ch(out_ch_a)
    );

    conv_bias_add_stream #(
        .NUM_CH(4), .NUM_PIX(2), .ACC_W(24), .ACC_FRAC(14), .RELU_EN(1'b1)
    ) u_relu (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .bias_row(bias_row_b), .bias_col(bias_col_b), .bias_data(bias_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ch(out_ch_b)
    );

    always @(posedge clk) begin
        if (out_valid_a && out_ready) n_out++;
        if (done_a) n_done++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] q8(input int v);
        return v[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int acc, input int ch, input int lin,
                        input int rel);
        int n = 0;
        in_valid = 1'b1;
        in_data  = acc[23:0];
        #1;
        while (!in_ready_a && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("in_ready", {31'd0, in_ready_a}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("out_valid", {31'd0, out_valid_a}, 32'd1);
        chk("out_ch", {16'd0, out_ch_a}, ch);
        chk("lin_data", {24'd0, out_data_a}, {24'd0, q8(lin)});
        chk("relu_data", {24'd0, out_data_b}, {24'd0, q8(rel)});
    endtask

    task automatic start_pass();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_a_run", {31'd0, busy_a}, 32'd1);
        chk("busy_b_run", {31'd0, busy_b}, 32'd1);
    endtask

    task automatic end_pass();
        chk("drain_busy", {31'd0, busy_a}, 32'd1);
        chk("drain_done", {31'd0, done_a}, 32'd0);
        step();
        chk("done_a", {31'd0, done_a}, 32'd1);
        chk("done_b", {31'd0, done_b}, 32'd1);
        chk("idle_busy", {31'd0, busy_a}, 32'd0);
        chk("idle_out_valid", {31'd0, out_valid_a}, 32'd0);
        step();
        chk("done_pulse_end", {31'd0, done_a}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 24'd0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
        chk("rst_out_data", {24'd0, out_data_a}, 32'd0);
        chk("rst_out_ch", {16'd0, out_ch_a}, 32'd0);
        chk("rst_bias_row", {16'd0, bias_row_a}, 32'd0);
        chk("rst_bias_col", {16'd0, bias_col_a}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_in_ready", {31'd0, in_ready_a}, 32'd0);

        // 1: zero accumulators expose the raw bias
        start_pass();
        for (int i = 0; i < 8; i++) begin
            push(0, i % 4, (i % 4) - 32, 0);
        end
        end_pass();

        // 2/3: saturation, floor rounding and ReLU
        start_pass();
        push(20480, 0, 127, 127);
        push(-640, 1, -36, 0);
        push(-1, 2, -31, 0);
        push(255, 3, -28, 0);
        push(-25600, 0, -128, 0);
        push(5120, 1, 9, 9);
        push(0, 2, -30, 0);
        push(0, 3, -29, 0);
        end_pass();

        // 4: downstream stall holds the result and blocks input
        start_pass();
        push(0, 0, -32, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 24'd1280;
        #1;
        chk("stall_in_ready0", {31'd0, in_ready_a}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", {31'd0, out_valid_a}, 32'd1);
            chk("stall_data", {24'd0, out_data_a}, {24'd0, q8(-32)});
            chk("stall_ch", {16'd0, out_ch_a}, 32'd0);
            chk("stall_in_ready", {31'd0, in_ready_a}, 32'd0);
        end
        out_ready = 1'b1;
        push(1280, 1, -21, 0);
        push(0, 2, -30, 0);
        push(0, 3, -29, 0);
        for (int i = 0; i < 4; i++) begin
            push(0, i, i - 32, 0);
        end
        end_pass();

        // 5: reset mid-pass
        start_pass();
        push(0, 0, -32, 0);
        push(0, 1, -31, 0);
        push(0, 2, -30, 0);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, out_valid_a}, 32'd0);
        chk("mid_rst_busy_a", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_busy_b", {31'd0, busy_b}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready_a}, 32'd0);
        rst = 1'b0;
        step();
        step();
        chk("mid_rst_no_done", {31'd0, done_a}, 32'd0);

        // 6: restart from channel 0; start during RUN is ignored
        base_out  = n_out;
        base_done = n_done;
        start_pass();
        push(0, 0, -32, 0);
        push(0, 1, -31, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_busy", {31'd0, busy_a}, 32'd1);
        chk("restart_row", {16'd0, bias_row_a}, 32'd2);
        chk("restart_gap_valid", {31'd0, out_valid_a}, 32'd0);
        push(0, 2, -30, 0);
        push(0, 3, -29, 0);
        for (int i = 0; i < 4; i++) begin
            push(0, i, i - 32, 0);
        end
        end_pass();
        step();
        step();
        chk("t6_outputs", n_out - base_out, 32'd8);
        chk("t6_dones", n_done - base_done, 32'd1);
        chk("t6_idle_busy", {31'd0, busy_a}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
